// File: rtl/prod_win_avg_if.sv
// prod_win_avg_if: sample/result bundle for the sliding-window averager.
//   clr  - synchronous clear, active-high
//   vld  - qualifies the product on `in`
//   in   - 2w-bit unsigned product from the upstream multiplier
//   sum  - 2w+lg bit sum of the products held in the window
//   avg  - 2w-bit window average (sum >> lg) while full, else 0
//   cnt  - lg+1 bit number of products held, 0..d
//   full - cnt == d
// master drives clr/vld/in and observes results; slave is the averager.
interface prod_win_avg_if #(
    parameter int unsigned w = 4,
    parameter int unsigned d = 4
);
    localparam int unsigned lg = $clog2(d);

    logic                  clr;
    logic                  vld;
    logic [2*w-1:0]        in;
    logic [2*w+lg-1:0]     sum;
    logic [2*w-1:0]        avg;
    logic [lg:0]           cnt;
    logic                  full;

    modport master (output clr, vld, in, input sum, avg, cnt, full);
    modport slave  (input clr, vld, in, output sum, avg, cnt, full);
endinterface

// File: rtl/prod_win_avg.sv
// prod_win_avg: sliding-window accumulator over the last d valid products.
//   clk   - rising-edge clock
//   rst_b - asynchronous reset, active-low
//   bus   - prod_win_avg_if slave: clr/vld/in in, sum/avg/cnt/full out
// Priority per edge: reset, clr, vld push, hold. All outputs are registered
// and reflect a push on the same edge that samples it.
module prod_win_avg #(
    parameter int unsigned w = 4,
    parameter int unsigned d = 4
) (
    input logic          clk,
    input logic          rst_b,
    prod_win_avg_if.slave bus
);
    localparam int unsigned lg = $clog2(d);
    localparam int unsigned PW = 2 * w;
    localparam int unsigned SW = 2 * w + lg;

    logic [PW-1:0] mem_q [d];
    logic [lg-1:0] wp_q;
    logic [SW-1:0] sum_q, sum_nxt;
    logic [PW-1:0] avg_q, avg_nxt;
    logic [PW-1:0] old;
    logic [lg:0]   cnt_q, cnt_nxt;
    logic          full_q, full_nxt;

    // Once full, wp points at the oldest entry, which this push evicts.
    always_comb begin
        old      = '0;
        if (full_q) old = mem_q[wp_q];
        sum_nxt  = sum_q + SW'(bus.in) - SW'(old);
        cnt_nxt  = full_q ? cnt_q : cnt_q + (lg+1)'(1);
        full_nxt = (cnt_nxt == (lg+1)'(d));
        avg_nxt  = '0;
        if (full_nxt) avg_nxt = sum_nxt[SW-1:lg];
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int unsigned i = 0; i < d; i++) mem_q[i] <= '0;
            wp_q   <= '0;
            sum_q  <= '0;
            avg_q  <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else if (bus.clr) begin
            for (int unsigned i = 0; i < d; i++) mem_q[i] <= '0;
            wp_q   <= '0;
            sum_q  <= '0;
            avg_q  <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else if (bus.vld) begin
            mem_q[wp_q] <= bus.in;
            wp_q   <= wp_q + lg'(1);
            sum_q  <= sum_nxt;
            avg_q  <= avg_nxt;
            cnt_q  <= cnt_nxt;
            full_q <= full_nxt;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.avg  = avg_q;
    assign bus.cnt  = cnt_q;
    assign bus.full = full_q;
endmodule

// File: tb/tb_prod_win_avg.sv
module tb_prod_win_avg;
    logic clk;
    logic rst_b;
    int unsigned passed;
    int unsigned total;

    int unsigned q4[$];
    int unsigned q8[$];

    prod_win_avg_if #(.w(4), .d(4)) b4 ();
    prod_win_avg_if #(.w(6), .d(8)) b8 ();

    prod_win_avg #(.w(4), .d(4)) dut4 (.clk(clk), .rst_b(rst_b), .bus(b4));
    prod_win_avg #(.w(6), .d(8)) dut8 (.clk(clk), .rst_b(rst_b), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: window is the list of the last d accepted products.
    function automatic logic [21:0] exp4();
        int unsigned s = 0;
        int unsigned n = q4.size();
        int unsigned a;
        foreach (q4[i]) s += q4[i];
        a = (n == 4) ? s / 4 : 0;
        return {10'(s), 8'(a), 3'(n), (n == 4)};
    endfunction

    function automatic logic [31:0] exp8();
        int unsigned s = 0;
        int unsigned n = q8.size();
        int unsigned a;
        foreach (q8[i]) s += q8[i];
        a = (n == 8) ? s / 8 : 0;
        return {15'(s), 12'(a), 4'(n), (n == 8)};
    endfunction

    function automatic logic [21:0] got4();
        return {b4.sum, b4.avg, b4.cnt, b4.full};
    endfunction

    function automatic logic [31:0] got8();
        return {b8.sum, b8.avg, b8.cnt, b8.full};
    endfunction

    // One clock edge of stimulus on the d=4 instance, with model update.
    task automatic step4(input logic c, input logic v, input int unsigned x);
        @(negedge clk);
        b4.clr = c; b4.vld = v; b4.in = 8'(x);
        @(posedge clk);
        #1;
        if (c) q4.delete();
        else if (v) begin
            q4.push_back(x & 8'hFF);
            if (q4.size() > 4) void'(q4.pop_front());
        end
        b4.clr = 1'b0; b4.vld = 1'b0;
    endtask

    task automatic step8(input logic c, input logic v, input int unsigned x);
        @(negedge clk);
        b8.clr = c; b8.vld = v; b8.in = 12'(x);
        @(posedge clk);
        #1;
        if (c) q8.delete();
        else if (v) begin
            q8.push_back(x & 12'hFFF);
            if (q8.size() > 8) void'(q8.pop_front());
        end
        b8.clr = 1'b0; b8.vld = 1'b0;
    endtask

    task automatic test_reset();
        logic [21:0] g;
        step4(1'b0, 1'b1, 7);
        step4(1'b0, 1'b1, 9);
        @(negedge clk);
        #1 rst_b = 1'b0;
        #1;
        q4.delete(); q8.delete();
        g = got4();
        total++;
        if (g !== 22'd0) $display("FAIL reset_async got=%h exp=0", g); else passed++;
        // Edges with vld/clr while held in reset must not change anything.
        b4.vld = 1'b1; b4.in = 8'd99;
        repeat (2) @(posedge clk);
        #1;
        g = got4();
        total++;
        if (g !== 22'd0) $display("FAIL reset_frozen got=%h exp=0", g); else passed++;
        b4.vld = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_fill();
        int unsigned vals[4] = '{50, 25, 10, 65};
        int unsigned sums[4] = '{50, 75, 85, 150};
        logic [21:0] e;
        for (int i = 0; i < 4; i++) begin
            step4(1'b0, 1'b1, vals[i]);
            e = exp4();
            total++;
            if (got4() !== e) $display("FAIL fill_%0d got=%h exp=%h", i, got4(), e); else passed++;
            total++;
            if (b4.sum !== 10'(sums[i])) $display("FAIL fill_sum_%0d got=%0d exp=%0d", i, b4.sum, sums[i]); else passed++;
        end
        total++;
        if (b4.avg !== 8'd37 || b4.full !== 1'b1) $display("FAIL fill_avg got=%0d/%0b exp=37/1", b4.avg, b4.full); else passed++;
    endtask

    task automatic test_evict_hold();
        logic [21:0] held;
        step4(1'b0, 1'b1, 169);
        total++;
        if (b4.sum !== 10'd269 || b4.avg !== 8'd67 || b4.cnt !== 3'd4)
            $display("FAIL evict_169 got=%0d/%0d/%0d exp=269/67/4", b4.sum, b4.avg, b4.cnt);
        else passed++;
        step4(1'b0, 1'b1, 0);
        total++;
        if (b4.sum !== 10'd244 || b4.avg !== 8'd61)
            $display("FAIL evict_zero got=%0d/%0d exp=244/61", b4.sum, b4.avg);
        else passed++;
        held = exp4();
        for (int i = 0; i < 3; i++) begin
            step4(1'b0, 1'b0, 200);
            total++;
            if (got4() !== held) $display("FAIL hold_%0d got=%h exp=%h", i, got4(), held); else passed++;
        end
    endtask

    task automatic test_clear();
        step4(1'b1, 1'b1, 225);
        total++;
        if (got4() !== 22'd0) $display("FAIL clr_prio got=%h exp=0", got4()); else passed++;
        step4(1'b0, 1'b1, 225);
        total++;
        if (b4.sum !== 10'd225 || b4.cnt !== 3'd1 || b4.avg !== 8'd0)
            $display("FAIL clr_next got=%0d/%0d/%0d exp=225/1/0", b4.sum, b4.cnt, b4.avg);
        else passed++;
    endtask

    task automatic test_saturate4();
        step4(1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            step4(1'b0, 1'b1, 225);
            if (i >= 3) begin
                total++;
                if (b4.sum !== 10'd900 || b4.avg !== 8'd225 || b4.full !== 1'b1)
                    $display("FAIL sat4_%0d got=%0d/%0d exp=900/225", i, b4.sum, b4.avg);
                else passed++;
            end
        end
    endtask

    task automatic test_saturate8();
        for (int i = 0; i < 9; i++) begin
            step8(1'b0, 1'b1, 3969);
            total++;
            if (got8() !== exp8()) $display("FAIL sat8_%0d got=%h exp=%h", i, got8(), exp8()); else passed++;
        end
        total++;
        if (b8.sum !== 15'd31752 || b8.avg !== 12'd3969 || b8.cnt !== 4'd8)
            $display("FAIL sat8_final got=%0d/%0d/%0d exp=31752/3969/8", b8.sum, b8.avg, b8.cnt);
        else passed++;
    endtask

    task automatic test_random();
        logic c, v;
        int unsigned x;
        for (int i = 0; i < 300; i++) begin
            c = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 9) < 7);
            x = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            step4(c, v, x);
            total++;
            if (got4() !== exp4()) $display("FAIL rand4_%0d got=%h exp=%h", i, got4(), exp4()); else passed++;
        end
        for (int i = 0; i < 200; i++) begin
            c = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 9) < 7);
            x = $urandom_range(0, 4095);
            step8(c, v, x);
            total++;
            if (got8() !== exp8()) $display("FAIL rand8_%0d got=%h exp=%h", i, got8(), exp8()); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        step4(1'b1, 1'b0, 0);
        step4(1'b0, 1'b1, 40);
        step4(1'b0, 1'b1, 60);
        @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        q4.delete(); q8.delete();
        total++;
        if (got4() !== 22'd0 || got8() !== 32'd0)
            $display("FAIL reset_mid got=%h/%h exp=0/0", got4(), got8());
        else passed++;
        #1 rst_b = 1'b1;
        step4(1'b0, 1'b1, 10);
        total++;
        if (b4.sum !== 10'd10 || b4.cnt !== 3'd1 || b4.avg !== 8'd0 || b4.full !== 1'b0)
            $display("FAIL reset_release got=%0d/%0d/%0d exp=10/1/0", b4.sum, b4.cnt, b4.avg);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_b  = 1'b0;
        b4.clr = 1'b0; b4.vld = 1'b0; b4.in = '0;
        b8.clr = 1'b0; b8.vld = 1'b0; b8.in = '0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        test_reset();
        test_fill();
        test_evict_hold();
        test_clear();
        test_saturate4();
        test_saturate8();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/prod_win_avg.md
# prod_win_avg

Sliding-window accumulator placed directly downstream of the last-two-values multiplier. It samples each 2w-bit product when the input is marked valid and keeps the last d accepted products in a circular buffer. From that buffer it maintains their running sum and, once the window is full, their average. All state updates happen on the clock edge; only reset is asynchronous.

## Interface
- w, default 4: operand width of the upstream multiplier; products are 2w bits.
- d, default 4: window depth. Must be a power of two, 2..16. lg = log2(d).
- clk  input  1  clock; all state changes on its rising edge, except reset.
- rst_b  input  1  asynchronous reset, active-low.
- clr  input  1  synchronous clear, active-high.
- vld  input  1  marks the product on `in` as valid; sampled on the rising edge of clk.
- in  input  2w  product from the upstream multiplier, unsigned.
- sum  output  2w+lg  sum of the products currently held in the window, unsigned.
- avg  output  2w  sum >> lg while the window is full; 0 otherwise.
- cnt  output  lg+1  number of products held, 0..d.
- full  output  1  high when cnt == d.

## Operation
- Storage: buffer of d entries, each 2w bits, plus a write pointer wp of lg bits.
  - wp wraps from d-1 to 0 with no extra logic (natural modulo-d).
  - The entry at wp is always the oldest product once the window is full.
- Priority per rising edge: rst_b low, then clr, then vld, then hold.
- Reset (rst_b = 0), applied immediately and asynchronously:
  - sum, avg, cnt, full, wp all 0.
  - Every buffer entry 0.
  - State stays frozen while rst_b is low, whatever clk, clr and vld do.
- clr = 1 at an edge:
  - Same effect as reset.
  - The product presented with vld on that edge is discarded.
- vld = 1 and clr = 0 at an edge (push):
  - old = buf[wp] if cnt == d, else 0.
  - buf[wp] <= in; wp <= wp + 1.
  - sum <= sum + in - old. Compute in 2w+lg bits; the result can never overflow, since sum ≤ d·(2^2w − 1).
  - cnt <= cnt + 1 while cnt < d; otherwise cnt stays at d.
  - full <= (next cnt == d).
  - avg <= (next cnt == d) ? (next sum >> lg) : 0. This is a truncating divide by d.
- vld = 0 and clr = 0 at an edge: all state holds.
- in is never filtered here. A product of 0 is a valid sample and is pushed like any other; value ignoring is the upstream block's job.

## Timing
- Every output is a register.
- Latency: sum, avg, cnt and full reflect a product at the same rising edge that samples it with vld.
- Back-to-back vld on every edge is supported with no stall. There is no backpressure output.
- The transition to full happens on the d-th push after reset or clr. avg becomes non-zero on that same edge if sum ≥ d.
- Eviction starts at push d+1. The evicted product is exactly the one pushed d pushes earlier.
- An rst_b assertion between edges zeroes all outputs within the same timestep, without waiting for clk. After rst_b deasserts, the first edge with vld = 1 is push 1.
- If rst_b rises on the same timestep as a clk rising edge, that edge is ignored.

## Test plan
All scenarios use w=4, d=4 unless stated otherwise.
- Reset: pulse rst_b low between edges -> sum, avg, cnt and full all read 0 immediately.
- Fill: push 50, 25, 10, 65 on consecutive edges ->
  - sum = 50, 75, 85, 150.
  - cnt = 1, 2, 3, 4.
  - full rises after the 4th push.
  - avg = 0, 0, 0, 37.
- Evict and hold:
  - Then push 169 -> sum = 269, avg = 67, cnt = 4.
  - Push 0 -> sum = 244, avg = 61 (25 evicted).
  - Then 3 edges with vld = 0 -> all outputs unchanged.
- Clear and clear priority:
  - clr = 1 together with vld = 1, in = 225 -> all outputs 0; the 225 is not stored.
  - Next push of 225 -> sum = 225, cnt = 1.
- Saturation, d=4: push 225 four times -> sum = 900, avg = 225. Fifth push of 225 -> sum stays 900.
- Saturation, w=6, d=8: push 3969 eight times -> sum = 31752, avg = 3969.
- Reset mid-stream: assert rst_b after 2 pushes -> everything is 0. After release, push 10 -> sum = 10, cnt = 1, avg = 0.
